// File: rtl/my9262_chain_ctrl_if.sv
// Avalon-MM slave bus bundle for the MY9262 chain controller.
// master: fabric side (drives address/strobes), slave: controller side.
interface my9262_chain_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/my9262_chain_ctrl.sv
// Serial frame driver for a daisy chain of MY9262 LED drivers.
// Ports: csi_clk/rsi_reset, avs (Avalon slave), ins_irq, coe_my9262_* pins.
module my9262_chain_ctrl #(
    parameter int DATA_W  = 16,
    parameter int N_WORDS = 16,
    parameter int ADDR_W  = 6,
    parameter int LAT_CYC = 4,
    parameter int DIV_W   = 16
) (
    input  logic                 csi_clk,
    input  logic                 rsi_reset,
    my9262_chain_ctrl_if.slave   avs,
    output logic                 ins_irq,
    output logic                 coe_my9262_Di,
    output logic                 coe_my9262_Dclk,
    output logic                 coe_my9262_Lat,
    output logic                 coe_my9262_Gck
);
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SH_LO, SH_HI, LATCH} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [N_WORDS];
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [BIT_W-1:0]  bitcnt;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  dclk_div, gck_div, gck_cnt;
    logic              cont, gck_en, irq_en, done, ovr, gck_q, busy;
    logic [31:0]       rd_mux;

    logic [31:0] wd;
    assign wd = avs.avs_writedata;

    logic ctrl_wr, start_req, buf_hit, cnt_zero, last_bit, last_word;
    logic latch_exit;
    logic [ADDR_W-1:0] buf_off;
    logic [IDX_W-1:0]  buf_idx;

    assign ctrl_wr   = avs.avs_write && (avs.avs_address == ADDR_W'(0));
    assign start_req = ctrl_wr && wd[0];
    // Wider compare so 8+N_WORDS == 2^ADDR_W does not wrap.
    assign buf_hit   = (avs.avs_address >= ADDR_W'(8)) &&
                       ({1'b0, avs.avs_address} < (ADDR_W+1)'(8 + N_WORDS));
    assign buf_off   = avs.avs_address - ADDR_W'(8);
    assign buf_idx   = buf_off[IDX_W-1:0];
    assign cnt_zero  = (cnt == '0);
    assign last_bit  = (bitcnt == '0);
    assign last_word = (idx == IDX_W'(N_WORDS - 1));
    assign latch_exit = (state == LATCH) && cnt_zero;

    logic unused_ok;
    assign unused_ok = ^wd;

    // State register
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) state <= IDLE;
        else           state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_req) state_n = LOAD;
            LOAD:  state_n = SH_LO;
            SH_LO: if (cnt_zero) state_n = SH_HI;
            SH_HI: if (cnt_zero) begin
                if (!last_bit)       state_n = SH_LO;
                else if (!last_word) state_n = LOAD;
                else                 state_n = LATCH;
            end
            LATCH: if (cnt_zero) state_n = cont ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register so that
    // an async reset drops the pins without waiting for a clock.
    always_comb begin
        busy            = (state != IDLE);
        coe_my9262_Dclk = (state == SH_HI);
        coe_my9262_Lat  = (state == LATCH);
        coe_my9262_Di   = ((state == SH_LO) || (state == SH_HI)) &&
                          shreg[DATA_W-1];
    end

    // Shift datapath; cnt counts down a half-period (or Lat time)
    // and is reloaded from the divider at each half-period start.
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            shreg  <= '0;
            idx    <= '0;
            bitcnt <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: idx <= '0;
                LOAD: begin
                    shreg  <= mem[idx];
                    bitcnt <= BIT_W'(DATA_W - 1);
                    cnt    <= dclk_div;
                end
                SH_LO: cnt <= cnt_zero ? dclk_div : cnt - 1'b1;
                SH_HI: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (!last_bit) begin
                        cnt    <= dclk_div;
                        shreg  <= shreg << 1;
                        bitcnt <= bitcnt - 1'b1;
                    end else if (!last_word) begin
                        idx <= idx + 1'b1;
                    end else begin
                        cnt <= DIV_W'(LAT_CYC - 1);
                    end
                end
                LATCH: begin
                    if (cnt_zero) idx <= '0;
                    else          cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control/status registers
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            cont     <= 1'b0;
            gck_en   <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            dclk_div <= '0;
            gck_div  <= '0;
        end else begin
            if (ctrl_wr) begin
                cont   <= wd[1];
                gck_en <= wd[2];
                irq_en <= wd[3];
            end
            if (avs.avs_write && avs.avs_address == ADDR_W'(1))
                dclk_div <= wd[DIV_W-1:0];
            if (avs.avs_write && avs.avs_address == ADDR_W'(2))
                gck_div <= wd[DIV_W-1:0];
            if (latch_exit)           done <= 1'b1;
            else if (ctrl_wr && wd[4]) done <= 1'b0;
            if (start_req && busy)    ovr <= 1'b1;
            else if (ctrl_wr && wd[5]) ovr <= 1'b0;
        end
    end

    // Frame buffer has no reset
    always_ff @(posedge csi_clk) begin
        if (avs.avs_write && buf_hit) mem[buf_idx] <= wd[DATA_W-1:0];
    end

    always_comb begin
        rd_mux = '0;
        if (avs.avs_address == ADDR_W'(0))
            rd_mux = {26'd0, ovr, done, irq_en, gck_en, cont, busy};
        else if (avs.avs_address == ADDR_W'(1))
            rd_mux = 32'(dclk_div);
        else if (avs.avs_address == ADDR_W'(2))
            rd_mux = 32'(gck_div);
        else if (buf_hit)
            rd_mux = 32'(mem[buf_idx]);
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset)         avs.avs_readdata <= '0;
        else if (avs.avs_read) avs.avs_readdata <= rd_mux;
    end

    // Free-running Gck; held in reload while disabled
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            gck_q   <= 1'b0;
            gck_cnt <= '0;
        end else if (!gck_en) begin
            gck_q   <= 1'b0;
            gck_cnt <= gck_div;
        end else if (gck_cnt == '0) begin
            gck_q   <= ~gck_q;
            gck_cnt <= gck_div;
        end else begin
            gck_cnt <= gck_cnt - 1'b1;
        end
    end

    // Gating with gck_en drops the pin as soon as the enable clears
    assign coe_my9262_Gck = gck_q & gck_en;
    assign ins_irq        = done & irq_en;
endmodule
